nrisc_ula_mc: RTL and testbench
===============================

Name: nrisc_ula_mc

Overview:
- Parametrised multi-cycle successor to the NRISC single-cycle ULA.
- Sits between register-file read and writeback. Uses a valid/ready request handshake and a one-cycle done pulse.
- Adds the following to the existing ops: multi-bit shifts/rotates by B, arithmetic shift right, iterative unsigned multiply, add/sub with carry-in, and compare.
- Single-cycle ops stream back-to-back. Multi-cycle ops stall the requester.

Parameters:
- TAM, 16, datapath width in bits (>=4, power of two).
- MUL_EN, 1, 1 = MUL implemented; 0 = code 1000 treated as reserved.
- SHW, $clog2(TAM), localparam, shift-amount width taken from ULA_B[SHW-1:0].

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active low.
- ULA_valid  in  1  request valid.
- ULA_ready  out  1  block can accept a request this cycle.
- ULA_ctrl  in  4  opcode, sampled on accept.
- ULA_A  in  TAM  operand A, sampled on accept.
- ULA_B  in  TAM  operand B / shift amount, sampled on accept.
- ULA_OUT  out  TAM  registered result.
- ULA_flags  out  3  registered {minus, zero, carry}.
- ULA_done  out  1  one-cycle pulse: ULA_OUT/ULA_flags just updated.

Behaviour:
- Reset (rst=0, async): ULA_OUT=0, ULA_flags=0, ULA_done=0, state=IDLE, ULA_ready=1. Any in-flight op is aborted with no done pulse.
- States:
  - IDLE: ULA_ready=1.
  - EXEC: ULA_ready=0; iterating.
- Accept = ULA_valid & ULA_ready at a rising edge. Operands and opcode are latched then; later input changes are ignored. ULA_valid while busy is ignored (requester must hold it).
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SHR, 0110 SHL, 0111 NOT (of A).
  - 1000 MUL, 1001 ADC, 1010 SBB, 1011 CMP.
  - 1100 ASR, 1101 ROR, 1110 ROL, 1111 reserved.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, ADC, SBB, CMP, reserved):
  - Result registered at the accept edge; ULA_done=1 for the following cycle.
  - State stays IDLE, so a new request may be accepted every cycle.
- Shift/rotate ops (SHR, SHL, ASR, ROR, ROL):
  - n = latched B[SHW-1:0].
  - n=0: single-cycle; OUT=A, carry=0.
  - n>0: enter EXEC and shift one bit per cycle. Result and done appear after exactly n cycles from accept.
  - SHR/SHL fill with 0; ASR fills with A[TAM-1]. carry = last bit shifted or rotated out.
- MUL:
  - Unsigned shift-add, one bit of B per cycle, TAM cycles in EXEC. Done asserts after exactly TAM cycles from accept.
  - OUT = low TAM bits of the product. carry=1 iff the high TAM bits are nonzero.
- Arithmetic ops:
  - ADD: carry = carry-out.
  - SUB: A-B; carry = borrow (1 iff A<B unsigned).
  - ADC: A+B+carry_flag. SBB: A-B-carry_flag. carry_flag is the flag value at accept time.
  - CMP: flags computed as for SUB; ULA_OUT unchanged.
- Flags:
  - minus = result[TAM-1].
  - zero = (result==0).
  - carry = 0 for AND, OR, XOR, NOT and reserved.
  - Flags hold between ops; they change only with a done pulse.
- Reserved opcode (1111, or 1000 with MUL_EN=0): OUT=0, flags={0,1,0}, single-cycle.
- Returning to IDLE: the done edge returns state to IDLE, and ULA_ready=1 in the done cycle. A request accepted in the done cycle is legal.
- Reset mid-EXEC: immediate abort. The first accept after rst deasserts behaves as from fresh reset.

Test Plan:
- ADD 0x7FFF+0x0001 -> OUT 0x8000, flags {1,0,0}, done 1 cycle after accept. ADD 0xFFFF+0x0001 -> 0x0000, flags {0,1,1}.
- SUB 0x0003-0x0005 -> 0xFFFE, flags {1,0,1}. Then SBB 0x0010-0x0001 -> 0x000E, flags {0,0,0}. Then CMP 0x0005,0x0005 -> OUT stays 0x000E, flags {0,1,0}.
- MUL 0x0100*0x0100 -> OUT 0x0000, flags {0,1,1}, done exactly 16 cycles after accept. ULA_ready=0 for cycles 1-15; a valid pulse mid-op is ignored. MUL 0x0003*0x0005 -> 0x000F, carry 0.
- Shifts:
  - SHL 0x8001, B=4 -> 0x0010, carry 0, latency 4.
  - ROR 0x0001, B=1 -> 0x8000, carry 1, latency 1.
  - ASR 0x8000, B=15 -> 0xFFFF, carry 0.
  - SHR with B=0 -> OUT=A, carry 0, latency 1.
- rst low at cycle 5 of a MUL -> OUT=0, flags=0, ready=1 immediately, no done. After release, ADD 1+1 -> 0x0002 normally.
- Five single-cycle ops on consecutive cycles (AND, OR, XOR, NOT, reserved) -> done high for 5 consecutive cycles, results in order. NOT 0x00FF -> 0xFF00. Reserved -> 0x0000, flags {0,1,0}.

Source files
------------

// File: rtl/nrisc_ula_mc.sv
// NRISC multi-cycle ULA: valid/ready request, registered result and flags, one-cycle done pulse.
// Shifts/rotates step one bit per cycle; MUL is an unsigned shift-add over TAM cycles.
module nrisc_ula_mc #(
    parameter int TAM    = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ULA_valid,
    output logic           ULA_ready,
    input  logic [3:0]     ULA_ctrl,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags,
    output logic           ULA_done
);

    localparam int SHW = $clog2(TAM);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
        OP_XOR = 4'b0100, OP_SHR = 4'b0101, OP_SHL = 4'b0110, OP_NOT = 4'b0111,
        OP_MUL = 4'b1000, OP_ADC = 4'b1001, OP_SBB = 4'b1010, OP_CMP = 4'b1011,
        OP_ASR = 4'b1100, OP_ROR = 4'b1101, OP_ROL = 4'b1110, OP_RSV = 4'b1111
    } op_e;

    typedef enum logic {S_IDLE, S_EXEC} state_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [TAM-1:0]     a_q, a_d;
    logic [2*TAM-1:0]   work_q, work_d;
    logic [TAM-1:0]     out_q, out_d;
    logic [2:0]         flags_q, flags_d;
    logic               done_q, done_d;

    function automatic logic [2:0] mk_flags(input logic [TAM-1:0] r, input logic c);
        return {r[TAM-1], r == '0, c};
    endfunction

    // Returns {bit shifted/rotated out, shifted word}.
    function automatic logic [TAM:0] shift_step(input op_e op, input logic [TAM-1:0] w);
        case (op)
            OP_SHR:  return {w[0], 1'b0, w[TAM-1:1]};
            OP_SHL:  return {w[TAM-1], w[TAM-2:0], 1'b0};
            OP_ASR:  return {w[0], w[TAM-1], w[TAM-1:1]};
            OP_ROR:  return {w[0], w[0], w[TAM-1:1]};
            default: return {w[TAM-1], w[TAM-2:0], w[TAM-1]};
        endcase
    endfunction

    // Right-shifting product register: {partial high, remaining multiplier bits}.
    function automatic logic [2*TAM-1:0] mul_step(input logic [2*TAM-1:0] p, input logic [TAM-1:0] a);
        logic [TAM:0] s;
        s = {1'b0, p[2*TAM-1:TAM]} + (p[0] ? {1'b0, a} : '0);
        return {s, p[TAM-1:1]};
    endfunction

    op_e            ctrl_op;
    logic [SHW-1:0] shamt;
    logic [TAM:0]   add_w, sub_w, adc_w, sbb_w;
    logic [TAM:0]   sh_w;
    logic [2*TAM-1:0] mul_w;

    assign ctrl_op = op_e'(ULA_ctrl);
    assign shamt   = ULA_B[SHW-1:0];
    assign add_w   = {1'b0, ULA_A} + {1'b0, ULA_B};
    assign sub_w   = {1'b0, ULA_A} - {1'b0, ULA_B};
    assign adc_w   = add_w + {{TAM{1'b0}}, flags_q[0]};
    // Top bit of the (TAM+1)-bit difference is the borrow.
    assign sbb_w   = sub_w - {{TAM{1'b0}}, flags_q[0]};

    // In IDLE the first step works straight off the request, so latency equals step count.
    assign sh_w  = shift_step((state_q == S_IDLE) ? ctrl_op : op_q,
                              (state_q == S_IDLE) ? ULA_A : work_q[TAM-1:0]);
    assign mul_w = mul_step((state_q == S_IDLE) ? {{TAM{1'b0}}, ULA_B} : work_q,
                            (state_q == S_IDLE) ? ULA_A : a_q);

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        work_d  = work_q;
        out_d   = out_q;
        flags_d = flags_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ULA_valid) begin
                    op_d   = ctrl_op;
                    a_d    = ULA_A;
                    done_d = 1'b1;
                    case (ctrl_op)
                        OP_ADD: begin
                            out_d   = add_w[TAM-1:0];
                            flags_d = mk_flags(add_w[TAM-1:0], add_w[TAM]);
                        end
                        OP_SUB: begin
                            out_d   = sub_w[TAM-1:0];
                            flags_d = mk_flags(sub_w[TAM-1:0], sub_w[TAM]);
                        end
                        OP_ADC: begin
                            out_d   = adc_w[TAM-1:0];
                            flags_d = mk_flags(adc_w[TAM-1:0], adc_w[TAM]);
                        end
                        OP_SBB: begin
                            out_d   = sbb_w[TAM-1:0];
                            flags_d = mk_flags(sbb_w[TAM-1:0], sbb_w[TAM]);
                        end
                        OP_CMP: flags_d = mk_flags(sub_w[TAM-1:0], sub_w[TAM]);
                        OP_AND: begin
                            out_d   = ULA_A & ULA_B;
                            flags_d = mk_flags(ULA_A & ULA_B, 1'b0);
                        end
                        OP_OR: begin
                            out_d   = ULA_A | ULA_B;
                            flags_d = mk_flags(ULA_A | ULA_B, 1'b0);
                        end
                        OP_XOR: begin
                            out_d   = ULA_A ^ ULA_B;
                            flags_d = mk_flags(ULA_A ^ ULA_B, 1'b0);
                        end
                        OP_NOT: begin
                            out_d   = ~ULA_A;
                            flags_d = mk_flags(~ULA_A, 1'b0);
                        end
                        OP_SHR, OP_SHL, OP_ASR, OP_ROR, OP_ROL: begin
                            if (shamt == '0) begin
                                out_d   = ULA_A;
                                flags_d = mk_flags(ULA_A, 1'b0);
                            end else if (shamt == SHW'(1)) begin
                                out_d   = sh_w[TAM-1:0];
                                flags_d = mk_flags(sh_w[TAM-1:0], sh_w[TAM]);
                            end else begin
                                done_d  = 1'b0;
                                work_d  = {{TAM{1'b0}}, sh_w[TAM-1:0]};
                                cnt_d   = shamt - SHW'(1);
                                state_d = S_EXEC;
                            end
                        end
                        OP_MUL: begin
                            if (MUL_EN) begin
                                done_d  = 1'b0;
                                work_d  = mul_w;
                                cnt_d   = SHW'(TAM - 1);
                                state_d = S_EXEC;
                            end else begin
                                out_d   = '0;
                                flags_d = 3'b010;
                            end
                        end
                        default: begin
                            out_d   = '0;
                            flags_d = 3'b010;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                if (cnt_q == SHW'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (op_q == OP_MUL) begin
                        out_d   = mul_w[TAM-1:0];
                        flags_d = mk_flags(mul_w[TAM-1:0], |mul_w[2*TAM-1:TAM]);
                    end else begin
                        out_d   = sh_w[TAM-1:0];
                        flags_d = mk_flags(sh_w[TAM-1:0], sh_w[TAM]);
                    end
                end else begin
                    cnt_d  = cnt_q - SHW'(1);
                    work_d = (op_q == OP_MUL) ? mul_w : {{TAM{1'b0}}, sh_w[TAM-1:0]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            a_q     <= '0;
            work_q  <= '0;
            out_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            work_q  <= work_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign ULA_ready = (state_q == S_IDLE);
    assign ULA_OUT   = out_q;
    assign ULA_flags = flags_q;
    assign ULA_done  = done_q;

endmodule

// File: tb/tb_nrisc_ula_mc.sv
// Directed bench for nrisc_ula_mc: expected results queued at request time, checked on each done pulse.
module tb_nrisc_ula_mc;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                           XOR_ = 4'b0100, SHR = 4'b0101, SHL = 4'b0110, NOT_ = 4'b0111,
                           MUL = 4'b1000, SBB = 4'b1010, CMP = 4'b1011,
                           ASR = 4'b1100, ROR = 4'b1101, ROL = 4'b1110, RSV = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        ULA_valid;
    logic        ULA_ready;
    logic [3:0]  ULA_ctrl;
    logic [15:0] ULA_A, ULA_B;
    logic [15:0] ULA_OUT;
    logic [2:0]  ULA_flags;
    logic        ULA_done;

    nrisc_ula_mc #(.TAM(16), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .ULA_valid (ULA_valid),
        .ULA_ready (ULA_ready),
        .ULA_ctrl  (ULA_ctrl),
        .ULA_A     (ULA_A),
        .ULA_B     (ULA_B),
        .ULA_OUT   (ULA_OUT),
        .ULA_flags (ULA_flags),
        .ULA_done  (ULA_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] out;
        logic [2:0]  flags;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding request, in value and in cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && ULA_done === 1'b1) begin
            check("done_has_request", 16'(sb.size() > 0), 16'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check({got.tag, "_out"}, ULA_OUT, got.out);
                check({got.tag, "_flags"}, 16'(ULA_flags), 16'(got.flags));
                check({got.tag, "_latency"}, 16'(cyc), 16'(got.cyc));
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge (cycle 1 of the op).
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic [2:0] ef, input int lat, input string tag);
        exp_t e;
        check({tag, "_ready"}, 16'(ULA_ready), 16'd1);
        ULA_ctrl  = op;
        ULA_A     = a;
        ULA_B     = b;
        ULA_valid = 1'b1;
        e.tag   = tag;
        e.out   = eo;
        e.flags = ef;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        @(posedge clk); #1;
        ULA_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drained"}, 16'(sb.size()), 16'd0);
        sb.delete();
    endtask

    initial begin
        rst       = 1'b0;
        ULA_valid = 1'b0;
        ULA_ctrl  = 4'h0;
        ULA_A     = 16'h0;
        ULA_B     = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", ULA_OUT, 16'h0000);
        check("reset_flags", 16'(ULA_flags), 16'h0);
        check("reset_done", 16'(ULA_done), 16'h0);
        check("reset_ready", 16'(ULA_ready), 16'h1);
        rst = 1'b1;
        @(posedge clk); #1;

        send(ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1, "add_ovf");
        send(ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b011, 1, "add_carry");
        send(SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b101, 1, "sub_borrow");
        send(SBB, 16'h0010, 16'h0001, 16'h000E, 3'b000, 1, "sbb");
        send(CMP, 16'h0005, 16'h0005, 16'h000E, 3'b010, 1, "cmp_eq");
        drain("arith");

        send(MUL, 16'h0100, 16'h0100, 16'h0000, 3'b011, 16, "mul_ovf");
        for (int i = 1; i <= 15; i++) begin
            check("mul_busy_ready", 16'(ULA_ready), 16'h0);
            if (i == 7) begin
                ULA_ctrl  = ADD;
                ULA_A     = 16'h1111;
                ULA_B     = 16'h2222;
                ULA_valid = 1'b1;
            end else begin
                ULA_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("mul_done_ready", 16'(ULA_ready), 16'h1);
        send(MUL, 16'h0003, 16'h0005, 16'h000F, 3'b000, 16, "mul_small");
        drain("mul");

        send(SHL, 16'h8001, 16'h0004, 16'h0010, 3'b000, 4, "shl4");
        drain("shl");
        send(ROR, 16'h0001, 16'h0001, 16'h8000, 3'b101, 1, "ror1");
        send(ROL, 16'h8000, 16'h0001, 16'h0001, 3'b001, 1, "rol1");
        drain("rot");
        send(ASR, 16'h8000, 16'h000F, 16'hFFFF, 3'b100, 15, "asr15");
        drain("asr");
        send(SHR, 16'h1234, 16'h0000, 16'h1234, 3'b000, 1, "shr0");
        drain("shr");

        send(MUL, 16'h0100, 16'h0100, 16'h0000, 3'b011, 16, "mul_abort");
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("abort_out", ULA_OUT, 16'h0000);
        check("abort_flags", 16'(ULA_flags), 16'h0);
        check("abort_ready", 16'(ULA_ready), 16'h1);
        check("abort_done", 16'(ULA_done), 16'h0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        send(ADD, 16'h0001, 16'h0001, 16'h0002, 3'b000, 1, "add_after_rst");
        drain("post_reset");

        send(ADD,  16'hFFFF, 16'h0001, 16'h0000, 3'b011, 1, "stream_add");
        send(AND_, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 1, "stream_and");
        send(OR_,  16'h0F00, 16'h00F0, 16'h0FF0, 3'b000, 1, "stream_or");
        send(XOR_, 16'hAAAA, 16'hAAAA, 16'h0000, 3'b010, 1, "stream_xor");
        send(NOT_, 16'h00FF, 16'h1234, 16'hFF00, 3'b100, 1, "stream_not");
        send(RSV,  16'h5555, 16'h0003, 16'h0000, 3'b010, 1, "stream_rsv");
        drain("stream");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
